// File: rtl/max_tracker.sv
// Frame max tracker over sign-magnitude samples; optional o_min via MAX_TRACKER_MIN_EN.
// Results registered one cycle after each transfer; o_ready high only while a frame runs.

module sm_cmp_ge #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_ge
);
    logic [N-1:0] w_key_a;
    logic [N-1:0] w_key_b;

    // Map sign-magnitude onto an unsigned key; -0 sorts just below +0.
    assign w_key_a = i_a[N-1] ? {1'b0, ~i_a[N-2:0]} : {1'b1, i_a[N-2:0]};
    assign w_key_b = i_b[N-1] ? {1'b0, ~i_b[N-2:0]} : {1'b1, i_b[N-2:0]};
    assign o_ge    = (w_key_a >= w_key_b);
endmodule

module max_tracker #(
    parameter int N         = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_valid,
    input  logic [N-1:0]                 i_data,
    output logic                         o_ready,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [N-1:0]                 o_max,
`ifdef MAX_TRACKER_MIN_EN
    output logic [N-1:0]                 o_min,
    output logic [$clog2(FRAME_LEN)-1:0] o_max_idx
`else
    output logic [$clog2(FRAME_LEN)-1:0] o_max_idx
`endif
);
    localparam int IW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_cnt;
    logic [N-1:0]    r_max;
    logic [IW-1:0]   r_max_idx;
    logic            w_ready;
    logic            w_busy;
    logic            w_done;
    logic            w_xfer;
    logic            w_first;
    logic            w_last;
    logic            w_max_ge;

    assign w_xfer  = i_valid & w_ready;
    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == IW'(FRAME_LEN - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_RUN;
            end
            S_RUN: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (w_xfer && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Counter holds at FRAME_LEN-1 after the last transfer; it is cleared on entry to RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && i_start) begin
            r_cnt <= '0;
        end else if (w_xfer && !w_last) begin
            r_cnt <= r_cnt + IW'(1);
        end
    end

    sm_cmp_ge #(.N(N)) u_cmp_max (
        .i_a  (r_max),
        .i_b  (i_data),
        .o_ge (w_max_ge)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_max     <= '0;
            r_max_idx <= '0;
        end else if (w_xfer && (w_first || !w_max_ge)) begin
            r_max     <= i_data;
            r_max_idx <= r_cnt;
        end
    end

`ifdef MAX_TRACKER_MIN_EN
    logic [N-1:0] r_min;
    logic         w_min_ge;

    sm_cmp_ge #(.N(N)) u_cmp_min (
        .i_a  (i_data),
        .i_b  (r_min),
        .o_ge (w_min_ge)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_min <= '0;
        end else if (w_xfer && (w_first || !w_min_ge)) begin
            r_min <= i_data;
        end
    end

    assign o_min = r_min;
`endif

    assign o_ready   = w_ready;
    assign o_busy    = w_busy;
    assign o_done    = w_done;
    assign o_max     = r_max;
    assign o_max_idx = r_max_idx;
endmodule
